cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 68 ++++++
 rtl/cpu_alu.sv | 13 +
 rtl/cpu_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared CPU definitions: data width, opcode map, sequencer state and decode payload.
package cpu_sequencer_pkg;

    localparam int unsigned W    = 4;
    localparam int unsigned OP_W = 4;
    localparam int unsigned IR_W = OP_W + W;

    localparam logic [OP_W-1:0] OP_ADD_A  = 4'b0000;
    localparam logic [OP_W-1:0] OP_MOV_AB = 4'b0001;
    localparam logic [OP_W-1:0] OP_IN_A   = 4'b0010;
    localparam logic [OP_W-1:0] OP_MOV_A  = 4'b0011;
    localparam logic [OP_W-1:0] OP_MOV_BA = 4'b0100;
    localparam logic [OP_W-1:0] OP_ADD_B  = 4'b0101;
    localparam logic [OP_W-1:0] OP_IN_B   = 4'b0110;
    localparam logic [OP_W-1:0] OP_MOV_B  = 4'b0111;
    localparam logic [OP_W-1:0] OP_OUT_B  = 4'b1001;
    localparam logic [OP_W-1:0] OP_OUT_I  = 4'b1011;
    localparam logic [OP_W-1:0] OP_JNC    = 4'b1110;
    localparam logic [OP_W-1:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2,
        SRC_IN   = 2'd3
    } src_t;

    typedef struct packed {
        src_t src;
        logic use_imm;
        logic load_a;
        logic load_b;
        logic load_out;
        logic is_add;
        logic is_jmp;
        logic is_jnc;
    } decode_t;

    // Unlisted opcodes fall through to an all-zero decode, i.e. a NOP.
    function automatic decode_t decode_op(input logic [OP_W-1:0] op);
        decode_t d;
        d     = '0;
        d.src = SRC_ZERO;
        case (op)
            OP_ADD_A:  begin d.src = SRC_A;  d.use_imm = 1'b1; d.load_a = 1'b1; d.is_add = 1'b1; end
            OP_ADD_B:  begin d.src = SRC_B;  d.use_imm = 1'b1; d.load_b = 1'b1; d.is_add = 1'b1; end
            OP_MOV_A:  begin d.use_imm = 1'b1; d.load_a = 1'b1; end
            OP_MOV_B:  begin d.use_imm = 1'b1; d.load_b = 1'b1; end
            OP_MOV_AB: begin d.src = SRC_B;  d.load_a = 1'b1; end
            OP_MOV_BA: begin d.src = SRC_A;  d.load_b = 1'b1; end
            OP_IN_A:   begin d.src = SRC_IN; d.load_a = 1'b1; end
            OP_IN_B:   begin d.src = SRC_IN; d.load_b = 1'b1; end
            OP_OUT_B:  begin d.src = SRC_B;  d.load_out = 1'b1; end
            OP_OUT_I:  begin d.use_imm = 1'b1; d.load_out = 1'b1; end
            OP_JMP:    d.is_jmp = 1'b1;
            OP_JNC:    d.is_jnc = 1'b1;
            default:   ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// W-bit adder producing sum and carry-out for the sequencer data path.
module cpu_alu
    import cpu_sequencer_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = (W+1)'(a) + (W+1)'(b);

endmodule

// File: rtl/cpu_sequencer.sv
// Two-cycle fetch/execute sequencer: owns pc, ir and carry, decodes ir into register-file strobes.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [W-1:0] RESET_PC = 4'd0
) (
    input  logic            clk_cpu,
    input  logic            reset,
    input  logic            run,
    input  logic [IR_W-1:0] rom_data,
    input  logic [W-1:0]    reg_a,
    input  logic [W-1:0]    reg_b,
    input  logic [W-1:0]    in_port,
    output logic [W-1:0]    rom_addr,
    output logic            load_a,
    output logic            load_b,
    output logic            load_out,
    output logic [W-1:0]    dat_out,
    output logic            carry,
    output logic            busy
);

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    pc;
    logic [W-1:0]    pc_next;
    logic [IR_W-1:0] ir;
    logic            carry_next;
    decode_t         dec;
    logic [W-1:0]    imm;
    logic [W-1:0]    src;
    logic [W-1:0]    alu_b;
    logic [W-1:0]    sum;
    logic            cout;

    // Decode depends only on the latched instruction, never on the live ROM bus.
    assign dec = decode_op(ir[IR_W-1:IR_W-OP_W]);
    assign imm = ir[W-1:0];

    always_comb begin
        src = '0;
        case (dec.src)
            SRC_A:   src = reg_a;
            SRC_B:   src = reg_b;
            SRC_IN:  src = in_port;
            default: src = '0;
        endcase
    end

    assign alu_b = dec.use_imm ? imm : '0;

    cpu_alu u_alu (
        .a    (src),
        .b    (alu_b),
        .sum  (sum),
        .cout (cout)
    );

    assign dat_out  = sum;
    assign rom_addr = pc;

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes come straight from the state register so reset clears them without a clock.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        carry_next = carry;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_out   = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                state_next = run ? ST_FETCH : ST_IDLE;
                load_a     = dec.load_a;
                load_b     = dec.load_b;
                load_out   = dec.load_out;
                pc_next    = pc + W'(1);
                if (dec.is_jmp || (dec.is_jnc && !carry)) begin
                    pc_next = imm;
                end
                carry_next = dec.is_add & cout;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            ir    <= '0;
            carry <= 1'b0;
        end else begin
            pc    <= pc_next;
            carry <= carry_next;
            if (state == ST_FETCH) begin
                ir <= rom_data;
            end
        end
    end

endmodule
